// File: rtl/rco_monitor.sv
// ---------------------------------------------------------------------------
// rco_monitor
//
// Watches an upstream 4-bit counter. It counts rising edges of the counter's
// ripple-carry-out into a saturating wrap counter. It also captures the
// counter value Q into a small show-ahead FIFO whenever the upstream counter
// is loaded.
//
// Build option:
//   RCO_MONITOR_STICKY_OVF_EN  When defined, overflow stays high from the
//                              first dropped push until reset or clr_cnt.
//                              When undefined, overflow is a one-cycle pulse
//                              in the cycle after each dropped push.
//
// Parameters:
//   CNT_W  width of the wrap counter (2..16)
//   DEPTH  capture FIFO depth (power of 2, 2..16); AW = log2(DEPTH)
//
// Ports:
//   clk         clock; all logic runs on its rising edge
//   reset       synchronous, active-high reset; has priority over everything
//   enable      monitor enable (FSM run request and FIFO push qualifier)
//   q_in        upstream counter value Q
//   rco_in      upstream ripple-carry-out
//   load_in     upstream load strobe (push request)
//   clr_cnt     synchronous clear of wrap counter, saturation and overflow
//   rd_en       FIFO pop request
//   wrap_count  number of counted rco rising edges (saturating)
//   sat         wrap_count is pinned at its maximum
//   fifo_data   FIFO head (show-ahead), 0 when empty
//   fifo_empty  FIFO holds no entries
//   fifo_full   FIFO holds DEPTH entries
//   fill        FIFO occupancy
//   overflow    a push was dropped because the FIFO was full
//   state       FSM state: IDLE=00, RUN=01, SAT=10
// ---------------------------------------------------------------------------
module rco_monitor #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       q_in,
    input  logic             rco_in,
    input  logic             load_in,
    input  logic             clr_cnt,
    input  logic             rd_en,
    output logic [CNT_W-1:0] wrap_count,
    output logic             sat,
    output logic [3:0]       fifo_data,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [AW:0]      fill,
    output logic             overflow,
    output logic [1:0]       state
);

`ifdef RCO_MONITOR_STICKY_OVF_EN
    localparam bit STICKY_OVF = 1'b1;
`else
    localparam bit STICKY_OVF = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SAT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    // One below the maximum: an edge seen here is the one that saturates.
    localparam logic [CNT_W-1:0] CNT_PRE    = CNT_MAX - CNT_W'(1);
    localparam logic [AW:0]      FULL_LEVEL = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // rco edge detection (register runs regardless of enable)
    // ------------------------------------------------------------------
    logic rco_reg;
    logic rco_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            rco_reg <= 1'b0;
        end else begin
            rco_reg <= rco_in;
        end
    end

    assign rco_edge = rco_in & ~rco_reg;

    // ------------------------------------------------------------------
    // Wrap counter FSM
    // ------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] wrap_count_reg;
    logic             sat_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            wrap_count_reg <= '0;
            sat_reg        <= 1'b0;
        end else if (clr_cnt) begin
            // Clear wins over any edge arriving in the same cycle.
            wrap_count_reg <= '0;
            sat_reg        <= 1'b0;
            state_reg      <= enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rco_edge && (wrap_count_reg >= CNT_PRE)) begin
                        // Saturating edge takes precedence over enable
                        // dropping, so the count is never lost.
                        wrap_count_reg <= CNT_MAX;
                        sat_reg        <= 1'b1;
                        state_reg      <= ST_SAT;
                    end else begin
                        if (rco_edge) begin
                            wrap_count_reg <= wrap_count_reg + CNT_W'(1);
                        end
                        if (!enable) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_SAT: begin
                    // Held until clr_cnt or reset; enable has no effect.
                    state_reg <= ST_SAT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO
    // ------------------------------------------------------------------
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   fill_reg;
    logic          overflow_reg;

    logic empty_int;
    logic full_int;
    logic push_req;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign empty_int = (fill_reg == '0);
    assign full_int  = (fill_reg == FULL_LEVEL);
    assign push_req  = load_in & enable;
    // A pop is only honoured when there is something to pop, so a push
    // and pop on an empty FIFO degenerates to a plain push.
    assign pop_ok    = rd_en & ~empty_int;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push_ok   = push_req & (~full_int | pop_ok);
    assign drop      = push_req & full_int & ~pop_ok;

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_reg] <= q_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop | (STICKY_OVF & overflow_reg);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wrap_count = wrap_count_reg;
    assign sat        = sat_reg;
    assign state      = state_reg;
    assign fill       = fill_reg;
    assign fifo_empty = empty_int;
    assign fifo_full  = full_int;
    assign overflow   = overflow_reg;
    assign fifo_data  = empty_int ? 4'd0 : mem[rd_ptr_reg];

endmodule

// File: tb/tb_rco_monitor.sv
// ---------------------------------------------------------------------------
// tb_rco_monitor
//
// Drives two rco_monitor instances from the same inputs: dut_a with default
// parameters (CNT_W=8, DEPTH=4) and dut_b with CNT_W=2 so saturation is
// reached quickly. A vector table covers the directed scenarios, hand-written
// sequences cover multi-cycle corners, and a random phase is compared against
// a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_rco_monitor;

`ifdef RCO_MONITOR_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_SAT  = 2;
    localparam int FDEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       rco_in = 1'b0;
    logic       load_in = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       rd_en = 1'b0;

    logic [7:0] wc_a;
    logic       sat_a;
    logic [3:0] data_a;
    logic       empty_a;
    logic       full_a;
    logic [2:0] fill_a;
    logic       ovf_a;
    logic [1:0] st_a;

    logic [1:0] wc_b;
    logic       sat_b;
    logic [3:0] data_b;
    logic       empty_b;
    logic       full_b;
    logic [2:0] fill_b;
    logic       ovf_b;
    logic [1:0] st_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rco_monitor #(.CNT_W(8), .DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .q_in(q_in),
        .rco_in(rco_in), .load_in(load_in), .clr_cnt(clr_cnt), .rd_en(rd_en),
        .wrap_count(wc_a), .sat(sat_a), .fifo_data(data_a),
        .fifo_empty(empty_a), .fifo_full(full_a), .fill(fill_a),
        .overflow(ovf_a), .state(st_a)
    );

    rco_monitor #(.CNT_W(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .q_in(q_in),
        .rco_in(rco_in), .load_in(load_in), .clr_cnt(clr_cnt), .rd_en(rd_en),
        .wrap_count(wc_b), .sat(sat_b), .fifo_data(data_b),
        .fifo_empty(empty_b), .fifo_full(full_b), .fill(fill_b),
        .overflow(ovf_b), .state(st_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit e, input bit c, input bit l,
                         input bit k, input bit d, input int q);
        reset   = r;
        enable  = e;
        rco_in  = c;
        load_in = l;
        clr_cnt = k;
        rd_en   = d;
        q_in    = 4'(q);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit r, e, c, l, k, d;
        int q;
        int wc, fill, data, st, ovp, ovs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit e, input bit c, input bit l,
                       input bit k, input bit d, input int q,
                       input int wc, input int fl, input int da, input int st,
                       input int ovp, input int ovs);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.l = l; v.k = k; v.d = d; v.q = q;
        v.wc = wc; v.fill = fl; v.data = da; v.st = st; v.ovp = ovp; v.ovs = ovs;
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int m_wc[2];
    int m_st[2];
    int m_sat[2];
    int m_max[2];
    bit m_prev;
    int m_ovf;
    int m_q[$];

    function automatic void model_step();
        bit edge_seen;
        bit push, pop, drop;
        edge_seen = rco_in && !m_prev;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_wc[k] = 0; m_st[k] = S_IDLE; m_sat[k] = 0;
            end
            m_prev = 0;
            m_ovf  = 0;
            m_q.delete();
            return;
        end
        m_prev = rco_in;
        for (int k = 0; k < 2; k++) begin
            if (clr_cnt) begin
                m_wc[k] = 0;
                m_sat[k] = 0;
                m_st[k] = enable ? S_RUN : S_IDLE;
            end else if (m_st[k] == S_IDLE) begin
                if (enable) m_st[k] = S_RUN;
            end else if (m_st[k] == S_RUN) begin
                if (edge_seen) begin
                    m_wc[k] = m_wc[k] + 1;
                    if (m_wc[k] == m_max[k]) begin
                        m_st[k] = S_SAT;
                        m_sat[k] = 1;
                    end
                end
                if (m_st[k] == S_RUN && !enable) m_st[k] = S_IDLE;
            end
        end
        push = load_in && enable;
        pop  = rd_en && (m_q.size() > 0);
        drop = push && !pop && (m_q.size() == FDEPTH);
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(int'(q_in));
        if (clr_cnt) m_ovf = 0;
        else if (drop) m_ovf = 1;
        else if (!STICKY) m_ovf = 0;
    endfunction

    task automatic check_model();
        int exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : 0;
        chk("rnd_wc_a",    int'(wc_a),    m_wc[0]);
        chk("rnd_sat_a",   int'(sat_a),   m_sat[0]);
        chk("rnd_state_a", int'(st_a),    m_st[0]);
        chk("rnd_wc_b",    int'(wc_b),    m_wc[1]);
        chk("rnd_sat_b",   int'(sat_b),   m_sat[1]);
        chk("rnd_state_b", int'(st_b),    m_st[1]);
        chk("rnd_fill",    int'(fill_a),  m_q.size());
        chk("rnd_data",    int'(data_a),  exp_data);
        chk("rnd_empty",   int'(empty_a), int'(m_q.size() == 0));
        chk("rnd_full",    int'(full_a),  int'(m_q.size() == FDEPTH));
        chk("rnd_ovf",     int'(ovf_a),   m_ovf);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_max[0] = 255;
        m_max[1] = 3;

        // ---- table: fields r,e,rco,ld,clr,rd,q | wc,fill,data,state,ovf_pulse,ovf_sticky
        add(1,0,0,0,0,0,0,  0,0,0,S_IDLE,0,0);
        add(0,1,0,0,0,0,0,  0,0,0,S_RUN,0,0);
        for (int i = 0; i < 5; i++) begin
            add(0,1,1,0,0,0,0,  i+1,0,0,S_RUN,0,0);
            add(0,1,0,0,0,0,0,  i+1,0,0,S_RUN,0,0);
        end
        for (int i = 1; i <= 4; i++) add(0,1,0,1,0,0,i,  5,i,1,S_RUN,0,0);
        add(0,1,0,1,0,0,5,  5,4,1,S_RUN,1,1);
        add(0,1,0,0,0,1,0,  5,3,2,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,2,3,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,1,4,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,0,0,S_RUN,0,1);
        for (int i = 0; i < 4; i++) add(0,1,0,1,0,0,6+i,  5,i+1,6,S_RUN,0,1);
        add(0,1,0,1,0,1,10, 5,4,7,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,3,8,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,2,9,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,1,10,S_RUN,0,1);
        add(0,1,0,0,0,1,0,  5,0,0,S_RUN,0,1);
        add(0,1,0,1,0,1,11, 5,1,11,S_RUN,0,1);
        add(0,1,0,0,1,0,0,  0,1,11,S_RUN,0,0);
        add(0,1,0,0,0,1,0,  0,0,0,S_RUN,0,0);
        for (int i = 0; i < 13; i++)
            add(0,1,(i%2==0),(i<3),0,0,12+i,  i/2+1,(i<3)?i+1:3,12,S_RUN,0,0);
        add(1,1,0,0,0,0,0,  0,0,0,S_IDLE,0,0);
        add(0,1,1,0,0,0,0,  0,0,0,S_RUN,0,0);
        add(0,1,1,0,0,0,0,  0,0,0,S_RUN,0,0);
        add(0,1,0,0,0,0,0,  0,0,0,S_RUN,0,0);
        add(0,1,1,0,0,0,0,  1,0,0,S_RUN,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].l, vecs[i].k, vecs[i].d, vecs[i].q);
            tick();
            chk("tbl_wc",    int'(wc_a),    vecs[i].wc);
            chk("tbl_fill",  int'(fill_a),  vecs[i].fill);
            chk("tbl_data",  int'(data_a),  vecs[i].data);
            chk("tbl_state", int'(st_a),    vecs[i].st);
            chk("tbl_ovf",   int'(ovf_a),   STICKY ? vecs[i].ovs : vecs[i].ovp);
            chk("tbl_empty", int'(empty_a), int'(vecs[i].fill == 0));
            chk("tbl_full",  int'(full_a),  int'(vecs[i].fill == FDEPTH));
            $display("vec %0d: wc=%0d fill=%0d data=%0d state=%0d ovf=%0d",
                     i, wc_a, fill_a, data_a, st_a, ovf_a);
        end

        // ---- rco held high for 10 cycles counts once
        drive(1,0,0,0,0,0,0); tick();
        drive(0,1,0,0,0,0,0); tick();
        drive(0,1,1,0,0,0,0);
        for (int i = 0; i < 10; i++) tick();
        chk("held_rco_wc", int'(wc_a), 1);
        chk("held_rco_state", int'(st_a), S_RUN);
        $display("seq held_rco: wc=%0d", wc_a);

        // ---- CNT_W=2 saturation, SAT holds with enable low, clr to IDLE
        drive(1,0,0,0,0,0,0); tick();
        drive(0,1,0,0,0,0,0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0,1,1,0,0,0,0); tick();
            drive(0,1,0,0,0,0,0); tick();
        end
        chk("sat2_wc", int'(wc_b), 3);
        chk("sat2_sat", int'(sat_b), 1);
        chk("sat2_state", int'(st_b), S_SAT);
        drive(0,0,0,0,0,0,0); tick(); tick(); tick();
        chk("sat2_hold_state", int'(st_b), S_SAT);
        chk("sat2_hold_wc", int'(wc_b), 3);
        drive(0,0,0,0,1,0,0); tick();
        chk("sat2_clr_wc", int'(wc_b), 0);
        chk("sat2_clr_state", int'(st_b), S_IDLE);
        chk("sat2_clr_sat", int'(sat_b), 0);
        $display("seq sat_cnt2: wc=%0d state=%0d", wc_b, st_b);

        // ---- CNT_W=8 saturation boundary
        drive(1,0,0,0,0,0,0); tick();
        drive(0,1,0,0,0,0,0); tick();
        for (int i = 0; i < 254; i++) begin
            drive(0,1,1,0,0,0,0); tick();
            drive(0,1,0,0,0,0,0); tick();
        end
        chk("sat8_pre_wc", int'(wc_a), 254);
        chk("sat8_pre_sat", int'(sat_a), 0);
        chk("sat8_pre_state", int'(st_a), S_RUN);
        for (int i = 0; i < 6; i++) begin
            drive(0,1,1,0,0,0,0); tick();
            drive(0,1,0,0,0,0,0); tick();
        end
        chk("sat8_wc", int'(wc_a), 255);
        chk("sat8_sat", int'(sat_a), 1);
        chk("sat8_state", int'(st_a), S_SAT);
        $display("seq sat_cnt8: wc=%0d state=%0d", wc_a, st_a);

        // ---- random phase against the reference model
        drive(1,0,0,0,0,0,0);
        model_step(); tick(); check_model();
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0,299) == 0),
                  ($urandom_range(0,7) != 0),
                  $urandom_range(0,1),
                  ($urandom_range(0,2) == 0),
                  ($urandom_range(0,59) == 0),
                  ($urandom_range(0,2) == 0),
                  int'($urandom_range(0,15)));
            model_step();
            tick();
            check_model();
            if (n % 500 == 499)
                $display("rnd %0d: wc_a=%0d wc_b=%0d fill=%0d state_b=%0d", n+1, wc_a, wc_b, fill_a, st_b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
